// File: rtl/riscv_div_unit.sv
// riscv_div_unit
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU. One quotient bit
// is produced per cycle using the shared add/sub unit, which this block
// drives through add_x/add_y/add_sub and reads back via add_sum/add_cout.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start_valid/start_ready    operand handshake (ready only when idle)
//   op                         00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend, divisor          rs1 / rs2 operands
//   flush                      synchronous kill of any in-flight operation
//   result_valid/result_ready  result handshake, result held until accepted
//   result                     quotient or remainder
//   busy                       high whenever not idle
//   add_x, add_y, add_sub      shared adder operands / subtract select
//   add_sum, add_cout          shared adder outputs
module riscv_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic [XLEN-1:0] add_x,
  output logic [XLEN-1:0] add_y,
  output logic            add_sub,
  input  logic [XLEN-1:0] add_sum,
  input  logic            add_cout
);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t          state, next_state;
  logic [4:0]      count;
  logic [XLEN-1:0] q_reg, r_reg, d_reg, result_reg;
  logic            is_rem_reg, neg_q_reg, neg_r_reg;

  logic            is_signed, accept, div_zero, overflow, special;
  logic            dividend_neg, divisor_neg;
  logic [XLEN-1:0] abs_dividend, abs_divisor, special_result;
  logic [XLEN-1:0] shifted, fix_val;
  logic            take, fix_neg;

  // Accept-time decode: operand signs, magnitudes and the two special cases
  // that bypass iteration entirely.
  assign is_signed    = ~op[0];
  assign accept       = (state == IDLE) & start_valid & ~flush;
  assign dividend_neg = is_signed & dividend[XLEN-1];
  assign divisor_neg  = is_signed & divisor[XLEN-1];
  assign abs_dividend = dividend_neg ? (~dividend + 1'b1) : dividend;
  assign abs_divisor  = divisor_neg  ? (~divisor  + 1'b1) : divisor;
  assign div_zero     = (divisor == '0);
  assign overflow     = is_signed & (dividend == {1'b1, {(XLEN-1){1'b0}}})
                        & (divisor == '1);
  assign special      = div_zero | overflow;

  always_comb begin
    special_result = '0;
    if (div_zero)
      special_result = op[1] ? dividend : '1;
    else
      special_result = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // Shifted partial remainder; R[31] set means the 33-bit value already
  // exceeds any divisor, so the subtract must be taken regardless of carry.
  assign shifted = {r_reg[XLEN-2:0], q_reg[XLEN-1]};
  assign take    = r_reg[XLEN-1] | add_cout;
  assign fix_val = is_rem_reg ? r_reg : q_reg;
  assign fix_neg = is_rem_reg ? neg_r_reg : neg_q_reg;

  assign start_ready  = (state == IDLE);
  assign busy         = (state != IDLE);
  assign result_valid = (state == DONE);
  assign result       = result_reg;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and adder drive. The adder is only claimed in ITER and FIX;
  // flush overrides every other transition.
  always_comb begin
    next_state = state;
    add_x      = '0;
    add_y      = '0;
    add_sub    = 1'b0;
    case (state)
      IDLE: if (start_valid) next_state = special ? DONE : ITER;
      ITER: begin
        add_x   = shifted;
        add_y   = d_reg;
        add_sub = 1'b1;
        if (count == 5'd0) next_state = FIX;
      end
      FIX: begin
        if (fix_neg) begin
          add_x   = '0;
          add_y   = fix_val;
          add_sub = 1'b1;
        end
        next_state = DONE;
      end
      DONE: if (result_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (flush) next_state = IDLE;
  end

  // Datapath registers: load on accept, shift/subtract in ITER, sign-fix in
  // FIX. The result register is left untouched after DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= 5'd0;
      q_reg      <= '0;
      r_reg      <= '0;
      d_reg      <= '0;
      result_reg <= '0;
      is_rem_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          is_rem_reg <= op[1];
          neg_q_reg  <= is_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
          neg_r_reg  <= dividend_neg;
          q_reg      <= abs_dividend;
          d_reg      <= abs_divisor;
          r_reg      <= '0;
          count      <= 5'd31;
          if (special) result_reg <= special_result;
        end
        ITER: begin
          r_reg <= take ? add_sum : shifted;
          q_reg <= {q_reg[XLEN-2:0], take};
          if (count != 5'd0) count <= count - 5'd1;
        end
        FIX: result_reg <= fix_neg ? add_sum : fix_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_div_unit.sv
// tb_riscv_div_unit
// Directed testbench for riscv_div_unit. Models the shared add/sub unit,
// runs hand-computed vectors and checks results, latency, backpressure,
// flush and asynchronous reset behaviour.
module tb_riscv_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        flush = 1'b0;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic [31:0] result;
  logic        busy;
  logic [31:0] add_x, add_y, add_sum;
  logic        add_sub, add_cout;

  int checks = 0;
  int failures = 0;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  riscv_div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .dividend(dividend), .divisor(divisor), .flush(flush),
    .result_valid(result_valid), .result_ready(result_ready),
    .result(result), .busy(busy),
    .add_x(add_x), .add_y(add_y), .add_sub(add_sub),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  // Shared adder: x + (sub ? ~y : y) + sub, carry-out on bit 32.
  always_comb begin
    {add_cout, add_sum} = {1'b0, add_x} + {1'b0, (add_sub ? ~add_y : add_y)}
                          + {32'd0, add_sub};
  end

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Present one operation and let it be accepted on the next rising edge;
  // returns #1 after the accept edge.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b);
    @(negedge clk);
    op = o;
    dividend = a;
    divisor = b;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
  endtask

  // Count edges from the accept edge until result_valid, bounded.
  task automatic waitResult(input string tag, input int exp_edges,
                            input logic [31:0] exp_result);
    int edges = 0;
    while (!result_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput({tag, "_latency"}, 32'(edges), 32'(exp_edges));
    checkOutput({tag, "_result"}, result, exp_result);
  endtask

  // Complete the result handshake and confirm the unit is idle again.
  task automatic acceptResult(input string tag);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    checkOutput({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic runOp(input string tag, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_result, input int exp_edges);
    applyStimulus(o, a, b);
    waitResult(tag, exp_edges, exp_result);
    acceptResult(tag);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid"}, {31'd0, result_valid}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_start_ready"}, {31'd0, start_ready}, 32'd1);
    checkOutput({tag, "_result"}, result, 32'd0);
    checkOutput({tag, "_add_x"}, add_x, 32'd0);
    checkOutput({tag, "_add_y"}, add_y, 32'd0);
    checkOutput({tag, "_add_sub"}, {31'd0, add_sub}, 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    int seen_valid;

    #1;
    checkResetOutputs("reset");
    #12;
    rst_n = 1'b1;

    // Normal operations: 33 edges after accept.
    runOp("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    runOp("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
    runOp("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    runOp("rem_m7_2", OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    runOp("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
    runOp("rem_7_m2", OP_REM, 32'd7, 32'hFFFFFFFE, 32'd1, 33);
    runOp("remu_big", OP_REMU, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 33);
    runOp("divu_big", OP_DIVU, 32'hFFFFFFFF, 32'h80000001, 32'd1, 33);
    runOp("divu_by1", OP_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33);

    // Special cases: valid in the cycle right after the accept edge.
    runOp("div_by0", OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 0);
    runOp("remu_by0", OP_REMU, 32'd5, 32'd0, 32'd5, 0);
    runOp("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
    runOp("rem_ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 0);

    // Backpressure: result and flags hold while result_ready stays low.
    applyStimulus(OP_DIVU, 32'd1000, 32'd9);
    waitResult("bp", 33, 32'd111);
    held = result;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_result_stable", result, held);
      checkOutput("bp_valid_held", {31'd0, result_valid}, 32'd1);
      checkOutput("bp_start_ready_low", {31'd0, start_ready}, 32'd0);
      checkOutput("bp_add_x_done", add_x, 32'd0);
    end
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    checkOutput("bp_start_ready_after", {31'd0, start_ready}, 32'd1);
    checkOutput("bp_valid_after", {31'd0, result_valid}, 32'd0);

    // Flush on the 10th ITER cycle (between edges E9 and E10).
    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    checkOutput("flush_busy_iter", {31'd0, busy}, 32'd1);
    checkOutput("flush_add_sub_iter", {31'd0, add_sub}, 32'd1);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush_busy", {31'd0, busy}, 32'd0);
    checkOutput("flush_start_ready", {31'd0, start_ready}, 32'd1);
    seen_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (result_valid) seen_valid++;
    end
    checkOutput("flush_no_valid", 32'(seen_valid), 32'd0);

    // Flush together with start_valid in IDLE must not accept.
    @(negedge clk);
    op = OP_DIVU;
    dividend = 32'd50;
    divisor = 32'd5;
    start_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    flush = 1'b0;
    checkOutput("flush_idle_no_accept", {31'd0, busy}, 32'd0);

    runOp("divu_after_flush", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);

    // Asynchronous reset mid-ITER.
    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    runOp("divu_after_rst", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
